// File: rtl/dcache_refill_pkg.sv
// rtl/dcache_refill_pkg.sv - shared types and constants for the data-cache line refill engine
//
// Contents:
//   LINE_WORDS      32-bit words per cache line
//   LINE_INDEX_LOW  lowest line-index address bit (line offset is addr[3:2])
//   TAG_LOW         lowest tag address bit
//   cache_tag_t     tag RAM entry {tag, valid, dirty}
//   refill_state_t  refill engine states
package dcache_refill_pkg;

    localparam int LINE_WORDS     = 4;
    localparam int LINE_INDEX_LOW = 4;
    localparam int TAG_LOW        = 12;

    typedef struct packed {
        logic [19:0] tag;
        logic        v;
        logic        d;
    } cache_tag_t;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WB_RD,
        ST_WB_AW,
        ST_WB_W,
        ST_WB_B,
        ST_RD_AR,
        ST_RD_R,
        ST_TAG_WR,
        ST_DONE
    } refill_state_t;

endpackage

// File: rtl/dcache_refill.sv
// rtl/dcache_refill.sv - data-cache miss engine: dirty-line writeback, line refill, tag update
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      miss request handshake; req_paddr, req_way (one-hot),
//                            req_dirty, req_victim_addr describe the miss
//   ar_valid/ar_ready/ar_addr  bus read address (line aligned)
//   r_valid/r_data/r_last    bus read-data beats, always accepted
//   aw_valid/aw_ready/aw_addr  bus write address (line aligned)
//   w_valid/w_ready/w_data/w_last  bus write-data beats
//   b_valid                  bus write response pulse
//   sram_addr/sram_way       SRAM port 1 word address and one-hot way
//   sram_strb/sram_wdata     SRAM data byte enables and write data
//   sram_rdata               SRAM read data, one cycle after sram_addr
//   sram_tag_we/sram_tag     tag write enable and entry
//   done                     one-cycle completion pulse
//   busy                     engine not idle
module dcache_refill
    import dcache_refill_pkg::*;
#(
    parameter int WORDS_PER_LINE = LINE_WORDS,
    parameter int INDEX_LOW      = LINE_INDEX_LOW
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_paddr,
    input  logic [1:0]  req_way,
    input  logic        req_dirty,
    input  logic [31:0] req_victim_addr,
    output logic        ar_valid,
    input  logic        ar_ready,
    output logic [31:0] ar_addr,
    input  logic        r_valid,
    input  logic [31:0] r_data,
    input  logic        r_last,
    output logic        aw_valid,
    input  logic        aw_ready,
    output logic [31:0] aw_addr,
    output logic        w_valid,
    input  logic        w_ready,
    output logic [31:0] w_data,
    output logic        w_last,
    input  logic        b_valid,
    output logic [31:0] sram_addr,
    output logic [1:0]  sram_way,
    output logic [3:0]  sram_strb,
    output logic [31:0] sram_wdata,
    input  logic [31:0] sram_rdata,
    output logic        sram_tag_we,
    output cache_tag_t  sram_tag,
    output logic        done,
    output logic        busy
);

    localparam logic [1:0] LAST_BEAT = 2'(WORDS_PER_LINE - 1);

    refill_state_t       state;
    logic [1:0]          cnt;
    logic                drain;
    logic                cap_vld;
    logic [1:0]          cap_idx;
    logic [31:INDEX_LOW] line_q;
    logic [31:INDEX_LOW] victim_q;
    logic [1:0]          way_q;
    logic [31:0]         buffer [WORDS_PER_LINE];
    logic                run;

    // The beat counter alone decides when the refill is complete; r_last is
    // not trusted, and the low address bits are implied by the line/beat.
    logic unused;
    assign unused = ^{r_last, req_paddr[INDEX_LOW-1:0], req_victim_addr[INDEX_LOW-1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            drain   <= 1'b0;
            cap_vld <= 1'b0;
        end else begin
            cap_vld <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        line_q   <= req_paddr[31:INDEX_LOW];
                        victim_q <= req_victim_addr[31:INDEX_LOW];
                        way_q    <= req_way;
                        cnt      <= '0;
                        drain    <= 1'b0;
                        state    <= req_dirty ? ST_WB_RD : ST_RD_AR;
                    end
                end
                // Four read issues, then one extra drain cycle so the last
                // word (one cycle of SRAM latency) lands in the buffer.
                ST_WB_RD: begin
                    if (!drain) begin
                        cap_vld <= 1'b1;
                        cap_idx <= cnt;
                        cnt     <= cnt + 2'd1;
                        if (cnt == LAST_BEAT) drain <= 1'b1;
                    end else begin
                        drain <= 1'b0;
                        cnt   <= '0;
                        state <= ST_WB_AW;
                    end
                end
                ST_WB_AW: begin
                    if (aw_ready) begin
                        cnt   <= '0;
                        state <= ST_WB_W;
                    end
                end
                ST_WB_W: begin
                    if (w_ready) begin
                        cnt <= cnt + 2'd1;
                        if (cnt == LAST_BEAT) state <= ST_WB_B;
                    end
                end
                ST_WB_B: begin
                    if (b_valid) state <= ST_RD_AR;
                end
                ST_RD_AR: begin
                    if (ar_ready) begin
                        cnt   <= '0;
                        state <= ST_RD_R;
                    end
                end
                ST_RD_R: begin
                    if (r_valid) begin
                        cnt <= cnt + 2'd1;
                        if (cnt == LAST_BEAT) state <= ST_TAG_WR;
                    end
                end
                ST_TAG_WR: state <= ST_DONE;
                ST_DONE:   state <= ST_IDLE;
                default:   state <= ST_IDLE;
            endcase
        end
    end

    // Writeback line buffer; contents are don't-care until filled.
    always_ff @(posedge clk) begin
        if (cap_vld) buffer[cap_idx] <= sram_rdata;
    end

    // Every strobe/valid is gated with rst so nothing is driven while in reset.
    assign run         = !rst;
    assign req_ready   = run && (state == ST_IDLE);
    assign busy        = run && (state != ST_IDLE);
    assign done        = run && (state == ST_DONE);

    assign aw_valid    = run && (state == ST_WB_AW);
    assign aw_addr     = {victim_q, {INDEX_LOW{1'b0}}};
    assign w_valid     = run && (state == ST_WB_W);
    assign w_data      = buffer[cnt];
    assign w_last      = w_valid && (cnt == LAST_BEAT);
    assign ar_valid    = run && (state == ST_RD_AR);
    assign ar_addr     = {line_q, {INDEX_LOW{1'b0}}};

    assign sram_way    = way_q;
    assign sram_addr   = (state == ST_RD_R) ? {line_q, cnt, 2'b00} : {victim_q, cnt, 2'b00};
    assign sram_strb   = (run && (state == ST_RD_R) && r_valid) ? 4'hF : 4'h0;
    assign sram_wdata  = r_data;
    assign sram_tag_we = run && (state == ST_TAG_WR);
    assign sram_tag    = '{tag: line_q[31:TAG_LOW], v: 1'b1, d: 1'b0};

endmodule

// File: tb/tb_dcache_refill.sv
// tb/tb_dcache_refill.sv - self-checking bench for dcache_refill
module tb_dcache_refill;
    import dcache_refill_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_dirty;
    logic [31:0] req_paddr, req_victim_addr;
    logic [1:0]  req_way;
    logic        ar_valid, ar_ready, r_valid, r_last;
    logic [31:0] ar_addr, r_data;
    logic        aw_valid, aw_ready, w_valid, w_ready, w_last, b_valid;
    logic [31:0] aw_addr, w_data;
    logic [31:0] sram_addr, sram_wdata, sram_rdata;
    logic [1:0]  sram_way;
    logic [3:0]  sram_strb;
    logic        sram_tag_we, done, busy;
    cache_tag_t  sram_tag;

    always #5 clk = ~clk;

    dcache_refill dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_paddr(req_paddr),
        .req_way(req_way), .req_dirty(req_dirty), .req_victim_addr(req_victim_addr),
        .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr),
        .r_valid(r_valid), .r_data(r_data), .r_last(r_last),
        .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_last(w_last),
        .b_valid(b_valid),
        .sram_addr(sram_addr), .sram_way(sram_way), .sram_strb(sram_strb),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
        .sram_tag_we(sram_tag_we), .sram_tag(sram_tag),
        .done(done), .busy(busy)
    );

    typedef struct packed {
        logic [31:0] paddr;
        logic [1:0]  way;
        logic        dirty;
        logic [31:0] victim;
        logic [31:0] lbase;
        logic [31:0] lstep;
        logic [31:0] vbase;
        logic [31:0] vstep;
        logic [3:0]  aw_dly;
        logic [3:0]  ar_dly;
        logic [3:0]  b_dly;
        logic [1:0]  wmode;
        logic        early;
        logic [1:0]  last_at;
        logic [31:0] exp_ar;
        logic [31:0] exp_aw;
        logic [19:0] exp_tag;
    } vec_t;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] word_of(input logic [31:0] base, input logic [31:0] step, input int i);
        return base + step * 32'(i);
    endfunction

    // One complete miss: the bench acts as bus slave and SRAM, records every
    // observable event, then compares against what the refill rules demand.
    task automatic run_txn(input vec_t v, input bit hold, input string nm);
        int cyc = 0, aw_seen = 0, ar_seen = 0, r_sent = 0, r_seen = 0, b_wait = 0;
        int b_cyc = -1, ar_first = -1, last_r_cyc = -1, tag_cyc = -1, done_n = 0, done_cyc = -1;
        int proto = 0, stab = 0, badwr = 0;
        bit accepted = 0, b_sent = 0, aw_pend = 0, w_pend = 0, ar_pend = 0;
        logic [31:0] aw_hold = 0, ar_hold = 0, w_hold = 0, prev_addr = 0;
        logic        wl_hold = 0;
        logic [31:0] aw_q[$], ar_q[$], w_q[$], wa_q[$], wd_q[$];
        logic        wl_q[$];
        logic [1:0]  ww_q[$], tw_q[$];
        logic [3:0]  ws_q[$];
        logic [21:0] tg_q[$];

        req_valid = 1; req_paddr = v.paddr; req_way = v.way; req_dirty = v.dirty;
        req_victim_addr = v.victim;
        aw_ready = 0; ar_ready = 0; w_ready = 0; b_valid = 0; r_valid = 0; r_last = 0;
        while (cyc < 400) begin
            @(negedge clk);
            if (req_valid && req_ready) accepted = 1;
            if (aw_pend && (!aw_valid || aw_addr !== aw_hold)) stab++;
            if (w_pend && (!w_valid || w_data !== w_hold || w_last !== wl_hold)) stab++;
            if (ar_pend && (!ar_valid || ar_addr !== ar_hold)) stab++;
            aw_pend = 0; w_pend = 0; ar_pend = 0;
            if (aw_valid) begin
                aw_seen++;
                if (aw_ready) aw_q.push_back(aw_addr);
                else begin aw_pend = 1; aw_hold = aw_addr; end
            end
            if (w_valid) begin
                if (w_ready) begin w_q.push_back(w_data); wl_q.push_back(w_last); end
                else begin w_pend = 1; w_hold = w_data; wl_hold = w_last; end
            end
            if (ar_valid) begin
                ar_seen++;
                if (ar_first < 0) ar_first = cyc;
                if (ar_ready) ar_q.push_back(ar_addr);
                else begin ar_pend = 1; ar_hold = ar_addr; end
            end
            if (b_valid) b_cyc = cyc;
            if (r_valid) begin
                if (r_last !== (r_seen == 3)) proto++;
                r_seen++;
                last_r_cyc = cyc;
            end
            if (sram_strb !== 4'h0) begin
                if (!r_valid) badwr++;
                wa_q.push_back(sram_addr); wd_q.push_back(sram_wdata);
                ww_q.push_back(sram_way); ws_q.push_back(sram_strb);
            end
            if (sram_tag_we) begin tg_q.push_back(sram_tag); tw_q.push_back(sram_way); tag_cyc = cyc; end
            if (done) begin done_n++; done_cyc = cyc; end
            prev_addr = sram_addr;
            @(posedge clk); #1;
            if (done_n > 0) break;
            if (accepted && !hold) req_valid = 0;
            aw_ready = v.early ? 1'b1 : (aw_valid && aw_seen >= int'(v.aw_dly));
            ar_ready = v.early ? 1'b1 : (ar_valid && ar_seen >= int'(v.ar_dly));
            case (v.wmode)
                2'd0:    w_ready = 1;
                2'd1:    w_ready = cyc[0];
                default: w_ready = 1'($urandom_range(0, 1));
            endcase
            b_valid = 0;
            if (v.dirty && w_q.size() == 4 && !b_sent) begin
                if (b_wait >= int'(v.b_dly)) begin b_valid = 1; b_sent = 1; end
                else b_wait++;
            end
            r_valid = 0; r_last = 0;
            if (ar_q.size() == 1 && r_sent < 4 && $urandom_range(0, 3) != 0) begin
                r_valid = 1;
                r_data  = word_of(v.lbase, v.lstep, r_sent);
                r_last  = (r_sent == int'(v.last_at));
                r_sent++;
            end
            sram_rdata = (prev_addr[31:4] == v.victim[31:4]) ?
                         word_of(v.vbase, v.vstep, int'(prev_addr[3:2])) : (32'hBAD0_0000 ^ prev_addr);
            cyc++;
        end
        check({nm, ".done_seen"}, done_n, 1);
        // Cycle after DONE: engine idle and ready again.
        aw_ready = 0; ar_ready = 0; w_ready = 0; b_valid = 0; r_valid = 0; r_last = 0;
        @(negedge clk);
        check({nm, ".done_pulse"}, done, 0);
        check({nm, ".post_busy"}, busy, 0);
        check({nm, ".post_ready"}, req_ready, 1);
        @(posedge clk); #1;
        if (hold) begin
            req_valid = 0;
            @(negedge clk);
            check({nm, ".b2b_busy"}, busy, 1);
            @(posedge clk); #1;
        end

        check({nm, ".ar_n"}, ar_q.size(), 1);
        check({nm, ".ar_addr"}, (ar_q.size() > 0) ? ar_q[0] : 32'hFFFF_FFFF, v.exp_ar);
        if (v.dirty) begin
            check({nm, ".aw_n"}, aw_q.size(), 1);
            check({nm, ".aw_addr"}, (aw_q.size() > 0) ? aw_q[0] : 32'hFFFF_FFFF, v.exp_aw);
            check({nm, ".w_n"}, w_q.size(), 4);
            for (int i = 0; i < 4; i++) begin
                check($sformatf("%s.w_data%0d", nm, i), (w_q.size() > i) ? w_q[i] : 32'hFFFF_FFFF,
                      word_of(v.vbase, v.vstep, i));
                check($sformatf("%s.w_last%0d", nm, i), (wl_q.size() > i) ? wl_q[i] : 1'bx, (i == 3));
            end
            check({nm, ".ar_after_b"}, (b_cyc >= 0) && (ar_first > b_cyc), 1);
        end else begin
            check({nm, ".no_wb"}, aw_q.size() + w_q.size(), 0);
        end
        check({nm, ".wr_n"}, wa_q.size(), 4);
        for (int i = 0; i < 4 && i < wa_q.size(); i++) begin
            check($sformatf("%s.wr_addr%0d", nm, i), wa_q[i], v.exp_ar + 32'(4 * i));
            check($sformatf("%s.wr_data%0d", nm, i), wd_q[i], word_of(v.lbase, v.lstep, i));
            check($sformatf("%s.wr_way%0d", nm, i), ww_q[i], v.way);
            check($sformatf("%s.wr_strb%0d", nm, i), ws_q[i], 4'hF);
        end
        check({nm, ".wr_same_cycle"}, badwr, 0);
        check({nm, ".tag_n"}, tg_q.size(), 1);
        check({nm, ".tag"}, (tg_q.size() > 0) ? tg_q[0] : 22'h3FFFFF, {v.exp_tag, 2'b10});
        check({nm, ".tag_way"}, (tw_q.size() > 0) ? tw_q[0] : 2'b11, v.way);
        check({nm, ".tag_cycle"}, tag_cyc, last_r_cyc + 1);
        check({nm, ".done_cycle"}, done_cyc, last_r_cyc + 2);
        check({nm, ".stable"}, stab, 0);
        check({nm, ".r_last_flags"}, proto, (v.last_at == 2'd3) ? 0 : 2);
    endtask

    task automatic apply_reset(input int n);
        rst = 1; req_valid = 0; aw_ready = 0; ar_ready = 0; w_ready = 0;
        b_valid = 0; r_valid = 0; r_last = 0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    vec_t vecs[6];

    initial begin
        #400000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    initial begin
        vec_t v;
        bit   seen;
        int   tw;

        vecs[0] = '{32'h1C00_0124, 2'b01, 1'b0, 32'h0, 32'hA0, 32'h1, 32'h0, 32'h0,
                    4'd0, 4'd0, 4'd0, 2'd0, 1'b0, 2'd3, 32'h1C00_0120, 32'h0, 20'h1C000};
        vecs[1] = '{32'h2000_5344, 2'b10, 1'b1, 32'h0000_5340, 32'h100, 32'h1, 32'h11, 32'h11,
                    4'd0, 4'd0, 4'd3, 2'd0, 1'b0, 2'd3, 32'h2000_5340, 32'h0000_5340, 20'h20005};
        vecs[2] = '{32'h3000_0F3C, 2'b01, 1'b1, 32'h7777_0F30, 32'hC0DE_0000, 32'h4, 32'hDEAD_BE00, 32'h10,
                    4'd5, 4'd2, 4'd1, 2'd1, 1'b0, 2'd3, 32'h3000_0F30, 32'h7777_0F30, 20'h30000};
        vecs[3] = '{32'h4ABC_DEF8, 2'b10, 1'b0, 32'h0, 32'h5555_0000, 32'h1111, 32'h0, 32'h0,
                    4'd0, 4'd1, 4'd0, 2'd0, 1'b0, 2'd2, 32'h4ABC_DEF0, 32'h0, 20'h4ABCD};
        vecs[4] = '{32'h0000_1010, 2'b01, 1'b1, 32'hFFFF_F014, 32'h1, 32'h2, 32'h9000_0000, 32'h3,
                    4'd0, 4'd0, 4'd2, 2'd2, 1'b1, 2'd3, 32'h0000_1010, 32'hFFFF_F010, 20'h00001};
        vecs[5] = '{32'hFFFF_FFFC, 2'b10, 1'b0, 32'h0, 32'hFFFF_FFFE, 32'h1, 32'h0, 32'h0,
                    4'd0, 4'd7, 4'd0, 2'd2, 1'b0, 2'd3, 32'hFFFF_FFF0, 32'h0, 20'hFFFFF};

        req_paddr = 0; req_way = 0; req_dirty = 0; req_victim_addr = 0;
        r_data = 0; sram_rdata = 0;
        apply_reset(3);
        @(negedge clk);
        check("rst.req_ready", req_ready, 0);
        check("rst.busy", busy, 0);
        check("rst.valids", {aw_valid, w_valid, ar_valid}, 3'b000);
        check("rst.sram_we", {sram_strb, sram_tag_we}, 5'h0);
        check("rst.done", done, 0);
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        check("idle.req_ready", req_ready, 1);
        check("idle.busy", busy, 0);
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) run_txn(vecs[i], 1'b0, $sformatf("vec%0d", i));

        for (int n = 0; n < 40; n++) begin
            v.paddr   = $urandom;
            v.way     = ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b01;
            v.dirty   = 1'($urandom_range(0, 1));
            v.victim  = $urandom;
            v.lbase   = $urandom; v.lstep = $urandom;
            v.vbase   = $urandom; v.vstep = $urandom;
            v.aw_dly  = 4'($urandom_range(0, 6));
            v.ar_dly  = 4'($urandom_range(0, 6));
            v.b_dly   = 4'($urandom_range(0, 6));
            v.wmode   = 2'($urandom_range(0, 2));
            v.early   = 1'($urandom_range(0, 1));
            v.last_at = 2'($urandom_range(0, 3));
            v.exp_ar  = v.paddr & 32'hFFFF_FFF0;
            v.exp_aw  = v.victim & 32'hFFFF_FFF0;
            v.exp_tag = 20'(v.paddr >> 12);
            run_txn(v, 1'b0, $sformatf("rnd%0d", n));
        end

        // req_valid held across DONE: next accept lands right after DONE.
        run_txn(vecs[0], 1'b1, "b2b");
        apply_reset(2);
        rst = 0;

        // Reset in the middle of the refill read phase, after beat 1.
        req_valid = 1; req_paddr = 32'h0BAD_F00C; req_way = 2'b01; req_dirty = 0;
        req_victim_addr = 0; ar_ready = 1; r_valid = 0;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (ar_valid && ar_ready) seen = 1;
            @(posedge clk); #1;
            req_valid = 0;
        end
        check("rst_mid.ar_seen", seen, 1);
        ar_ready = 0;
        r_valid = 1; r_data = 32'h1111_0000;
        @(negedge clk);
        check("rst_mid.beat0_strb", sram_strb, 4'hF);
        @(posedge clk); #1;
        r_data = 32'h1111_0001;
        @(negedge clk);
        check("rst_mid.beat1_addr", sram_addr, 32'h0BAD_F004);
        @(posedge clk); #1;
        rst = 1; r_data = 32'h1111_0002;
        @(negedge clk);
        check("rst_mid.strb_in_rst", sram_strb, 4'h0);
        check("rst_mid.ready_in_rst", {req_ready, busy, sram_tag_we}, 3'b000);
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        check("rst_mid.idle", busy, 0);
        check("rst_mid.req_ready", req_ready, 1);
        check("rst_mid.no_write", sram_strb, 4'h0);
        @(posedge clk); #1;
        r_valid = 0;
        tw = 0;
        repeat (4) begin
            @(negedge clk);
            if (sram_tag_we || done) tw++;
            @(posedge clk); #1;
        end
        check("rst_mid.no_tag", tw, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
